instr_prefetch_queue: RTL

- Parametrised instruction prefetch unit: generates addresses into the synchronous instruction memory (1-cycle read latency) and buffers returned words in a DEPTH-entry FIFO.
- Presents them to the cpu through a valid/ready handshake, with a zero-latency bypass when empty.
- Flushes on a branch redirect (load_pc).
- Replaces the fixed instruction queue plus its empty/bypass select in the integrated top level.

---
 rtl/instr_prefetch_queue_pkg.sv | 13 +
 rtl/instr_prefetch_queue_sync_fifo.sv | 52 +++++
 rtl/instr_prefetch_queue.sv | 85 ++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// instr_prefetch_queue_pkg: shared defaults and the fetched-word record used by the prefetch queue.
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH : default instruction width, PC width, FIFO depth
//   fetch_entry_t                        : {instr, pc} record at the default widths
package instr_prefetch_queue_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DEPTH  = 4;
    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// instr_prefetch_queue_sync_fifo: synchronous FIFO of fetched words with flush and occupancy count.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : empties the FIFO at the next edge (same effect as rst)
//   push, din : write din at the tail
//   pop, dout : dout is the head entry, pop advances past it
//   count     : number of stored entries (0..DEPTH)
module instr_prefetch_queue_sync_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  T                           din,
    input  logic                       pop,
    output T                           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; stale entries are never visible because count gates reads.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= din;
    end

    // The issue throttle upstream guarantees a full FIFO never receives a push without a pop.
    always_ff @(posedge clk) begin
        if (!rst && !flush) assert (!(push && !pop && count == CW'(DEPTH)));
    end
endmodule

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: instruction prefetcher with 1-cycle memory, DEPTH-entry FIFO and empty bypass.
// Ports:
//   clk, rst              : clock, synchronous active-high reset (loads start_pc)
//   start_pc              : PC loaded while rst=1
//   redirect, redirect_pc : branch redirect, flushes queue and refetches from redirect_pc
//   mem_addr, mem_rd_en   : instruction memory request
//   mem_rdata             : memory data, valid the cycle after the request
//   instr_out, instr_pc   : head instruction and its PC
//   instr_valid           : head valid; consumed when instr_ready=1
//   instr_ready           : cpu accepts head
//   count                 : FIFO occupancy, not counting a bypassed word
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          start_pc,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd_en,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [DATA_W-1:0]          instr_out,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic              resp_valid, issue, head_valid, pop, push, fifo_pop;
    entry_t            head;

    // The issue throttle counts the in-flight word as occupied and ignores a same-cycle pop,
    // so instr_ready never reaches mem_addr/mem_rd_en combinationally.
    always_comb begin
        issue       = ~rst & (redirect | (int'(count) + int'(resp_valid) < DEPTH));
        mem_addr    = (redirect & ~rst) ? redirect_pc : fetch_pc;
        mem_rd_en   = issue;
        head_valid  = count != '0;
        instr_valid = ~rst & ~redirect & (head_valid | resp_valid);
        instr_out   = head_valid ? head.instr : mem_rdata;
        instr_pc    = head_valid ? head.pc : resp_pc;
        pop         = instr_valid & instr_ready;
        fifo_pop    = pop & head_valid;
        // A returning word is stored unless the cpu took it straight from the bypass path.
        push        = resp_valid & ~redirect & (head_valid | ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= start_pc;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
        end else begin
            resp_valid <= issue;
            if (issue) begin
                fetch_pc <= mem_addr + ADDR_W'(1);
                resp_pc  <= mem_addr;
            end
        end
    end

    instr_prefetch_queue_sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .din   ('{instr: mem_rdata, pc: resp_pc}),
        .pop   (fifo_pop),
        .dout  (head),
        .count (count)
    );
endmodule
